mips_dmem_arbiter: RTL and testbench

MIPS_DMEM_ARBITER -- requirements
Module: mips_dmem_arbiter

---
 rtl/mips_dmem_arbiter_pkg.sv | 26 ++
 rtl/mips_dmem_arbiter_if.sv | 53 +++++
 rtl/mips_rr_arbiter2.sv | 44 ++++
 rtl/mips_dmem_arbiter.sv | 113 +++++++++++
 tb/tb_mips_dmem_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mips_dmem_arbiter_pkg.sv
// Shared types and constants for the MIPS data-memory arbiter.
// Build option: MIPS_DMEM_ARB_RR_EN selects round-robin arbitration.
package mips_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic is_ill(
    input logic       we,
    input logic [1:0] size
  );
    return we && (size == SZ_ILL);
  endfunction

endpackage

// File: rtl/mips_dmem_arbiter_if.sv
// Requester and memory-port bundle of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mips_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [1:0]        dbg_size;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] write_data;
  logic              sig_mem_read;
  logic              sig_mem_write;
  logic [1:0]        s;
  logic [DATA_W-1:0] read_data;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_err,
    output mem_address, write_data, sig_mem_read, sig_mem_write, s,
    input  read_data,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_err,
    input  mem_address, write_data, sig_mem_read, sig_mem_write, s,
    output read_data,
    input  busy
  );

endinterface

// File: rtl/mips_rr_arbiter2.sv
// Two-way grant: fixed cpu priority, or round-robin pointer when
// MIPS_DMEM_ARB_RR_EN is defined.
module mips_rr_arbiter2
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_id,
  output logic       any
);

`ifdef MIPS_DMEM_ARB_RR_EN
  logic ptr;

  // Pointer only moves when both requesters actually contend.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= ID_CPU;
    else if (en && (&req))
      ptr <= ~gnt_id;
  end

  always_comb begin
    gnt_id = ID_CPU;
    unique case (1'b1)
      &req:   gnt_id = ptr;
      req[1]: gnt_id = ID_DBG;
      default: gnt_id = ID_CPU;
    endcase
  end
`else
  logic unused;
  assign unused = ^{clk, rst, en};

  always_comb begin
    gnt_id = req[0] ? ID_CPU : ID_DBG;
  end
`endif

  assign any = |req;

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Data-memory arbiter between cpu and dbg requesters.
// Build option: MIPS_DMEM_ARB_RR_EN (round-robin, else cpu priority).
module mips_dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  mips_dmem_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic              cur_id;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic [1:0] req_vis;
  logic       arb_pt;
  logic       gnt_id;
  logic       any_req;
  logic       cur_ill;
  logic       rd;
  logic       wr;

  // The requester just acked is masked while its req is still up.
  always_comb begin
    req_vis = {bus.dbg_req, bus.cpu_req};
    if (state == DONE)
      req_vis[cur_id] = 1'b0;
  end

  assign arb_pt  = (state != ACCESS);
  assign cur_ill = is_ill(cur_we, cur_size);

  mips_rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vis),
    .en     (arb_pt),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = any_req ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id    <= ID_CPU;
      cur_we    <= 1'b0;
      cur_size  <= SZ_WORD;
      cur_addr  <= '0;
      cur_wdata <= '0;
    end else if (arb_pt && any_req) begin
      cur_id    <= gnt_id;
      cur_we    <= gnt_id ? bus.dbg_we    : bus.cpu_we;
      cur_size  <= gnt_id ? bus.dbg_size  : bus.cpu_size;
      cur_addr  <= gnt_id ? bus.dbg_addr  : bus.cpu_addr;
      cur_wdata <= gnt_id ? bus.dbg_wdata : bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (rd) begin
      if (cur_id == ID_DBG)
        dbg_rdata_q <= bus.read_data;
      else
        cpu_rdata_q <= bus.read_data;
    end
  end

  always_comb begin
    rd = (state == ACCESS) && !cur_we;
    wr = (state == ACCESS) && cur_we && !cur_ill;
    bus.sig_mem_read  = rd;
    bus.sig_mem_write = wr;
    bus.mem_address   = (rd || wr) ? cur_addr  : '0;
    bus.write_data    = (rd || wr) ? cur_wdata : '0;
    bus.s             = (rd || wr) ? cur_size  : SZ_WORD;
    bus.cpu_ack = (state == DONE) && (cur_id == ID_CPU);
    bus.dbg_ack = (state == DONE) && (cur_id == ID_DBG);
    bus.cpu_err = bus.cpu_ack && cur_ill;
    bus.dbg_err = bus.dbg_ack && cur_ill;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dbg_rdata = dbg_rdata_q;
    bus.busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed bench for mips_dmem_arbiter: vector table plus
// contention, streaming and reset-abort sequences.
module tb_mips_dmem_arbiter;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign bus.read_data = bus.sig_mem_read ? mem_val(bus.mem_address) : '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        dbg;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rd;
    logic        e_wr;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t v[8];

  task automatic drive(input logic dbg, input logic we,
                       input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_size = size;
      bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_size = size;
      bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  task automatic idle_all();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = SZ_WORD;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_size = SZ_WORD;
    bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic pair(input logic first_dbg);
    logic [31:0] a1, a2, d2;
    a1 = first_dbg ? 32'h8 : 32'h4;
    a2 = first_dbg ? 32'h4 : 32'h8;
    d2 = first_dbg ? 32'h11111111 : 32'hAB;
    drive(1'b0, 1'b1, SZ_WORD, 32'h4, 32'h11111111);
    drive(1'b1, 1'b1, SZ_BYTE, 32'h8, 32'hAB);
    @(posedge clk); @(negedge clk);
    chk("pair1_wr", bus.sig_mem_write, 1);
    chk("pair1_addr", bus.mem_address, a1);
    @(negedge clk);
    chk("pair1_ack", first_dbg ? bus.dbg_ack : bus.cpu_ack, 1);
    if (first_dbg) bus.dbg_req = 1'b0;
    else bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("pair2_addr", bus.mem_address, a2);
    chk("pair2_wdata", bus.write_data, d2);
    @(negedge clk);
    chk("pair2_ack", first_dbg ? bus.cpu_ack : bus.dbg_ack, 1);
    idle_all();
    @(negedge clk);
    chk("pair_busy", bus.busy, 0);
  endtask

  initial begin
    v[0] = '{0, 0, SZ_WORD, 32'h10, 32'h0, 1, 0, 0, 32'hDEADBEEF};
    v[1] = '{1, 0, SZ_WORD, 32'h20, 32'h0, 1, 0, 0, 32'hA5A50020};
    v[2] = '{0, 1, SZ_WORD, 32'h4, 32'h11111111, 0, 1, 0, 32'hDEADBEEF};
    v[3] = '{1, 1, SZ_BYTE, 32'h8, 32'hAB, 0, 1, 0, 32'hA5A50020};
    v[4] = '{1, 1, SZ_ILL, 32'hC, 32'h55, 0, 0, 1, 32'hA5A50020};
    v[5] = '{0, 1, SZ_HALF, 32'hC, 32'h1234, 0, 1, 0, 32'hDEADBEEF};
    v[6] = '{0, 1, SZ_ILL, 32'h1C, 32'h77, 0, 0, 1, 32'hDEADBEEF};
    v[7] = '{0, 0, SZ_ILL, 32'h3, 32'h0, 1, 0, 0, 32'hA5A50003};

    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd", bus.sig_mem_read, 0);
    chk("rst_wr", bus.sig_mem_write, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_acks", {bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.dbg_err}, 0);
    chk("rst_rdata", bus.cpu_rdata | bus.dbg_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic st;
      st = v[i].e_rd | v[i].e_wr;
      drive(v[i].dbg, v[i].we, v[i].size, v[i].addr, v[i].wdata);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_rd", i), bus.sig_mem_read, v[i].e_rd);
      chk($sformatf("v%0d_wr", i), bus.sig_mem_write, v[i].e_wr);
      chk($sformatf("v%0d_addr", i), bus.mem_address, st ? v[i].addr : 0);
      chk($sformatf("v%0d_wdata", i), bus.write_data, st ? v[i].wdata : 0);
      chk($sformatf("v%0d_s", i), bus.s, st ? v[i].size : 0);
      chk($sformatf("v%0d_early_ack", i), bus.cpu_ack | bus.dbg_ack, 0);
      chk($sformatf("v%0d_busy", i), bus.busy, 1);
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), v[i].dbg ? bus.dbg_ack : bus.cpu_ack, 1);
      chk($sformatf("v%0d_oack", i), v[i].dbg ? bus.cpu_ack : bus.dbg_ack, 0);
      chk($sformatf("v%0d_err", i), v[i].dbg ? bus.dbg_err : bus.cpu_err,
          v[i].e_err);
      chk($sformatf("v%0d_rdata", i),
          v[i].dbg ? bus.dbg_rdata : bus.cpu_rdata, v[i].e_rdata);
      chk($sformatf("v%0d_strobe_off", i),
          bus.sig_mem_read | bus.sig_mem_write, 0);
      idle_all();
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), bus.busy, 0);
    end

    pair(1'b0);
`ifdef MIPS_DMEM_ARB_RR_EN
    pair(1'b1);
`else
    pair(1'b0);
`endif

    drive(1'b0, 1'b0, SZ_WORD, 32'h40, 32'h0);
    drive(1'b1, 1'b0, SZ_WORD, 32'h44, 32'h0);
    @(posedge clk);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk($sformatf("st%0d_busy_a", t), bus.busy, 1);
      chk($sformatf("st%0d_rd", t), bus.sig_mem_read, 1);
      chk($sformatf("st%0d_addr", t), bus.mem_address,
          (t % 2 == 0) ? 32'h40 : 32'h44);
      @(negedge clk);
      chk($sformatf("st%0d_busy_d", t), bus.busy, 1);
      chk($sformatf("st%0d_ack", t), {bus.dbg_ack, bus.cpu_ack},
          (t % 2 == 0) ? 2'b01 : 2'b10);
      if (t == 9) idle_all();
    end
    @(negedge clk);
    chk("st_end_busy", bus.busy, 0);
    chk("st_cpu_rdata", bus.cpu_rdata, 32'hA5A50040);
    chk("st_dbg_rdata", bus.dbg_rdata, 32'hA5A50044);

    drive(1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("ra_rd", bus.sig_mem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("ra_ack", bus.cpu_ack | bus.dbg_ack, 0);
    chk("ra_strobe", bus.sig_mem_read | bus.sig_mem_write, 0);
    chk("ra_busy", bus.busy, 0);
    chk("ra_addr", bus.mem_address, 0);
    chk("ra_rdata", bus.cpu_rdata | bus.dbg_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ra_ack2", bus.cpu_ack, 0);
    chk("rn_rd", bus.sig_mem_read, 1);
    @(negedge clk);
    chk("rn_ack", bus.cpu_ack, 1);
    chk("rn_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    idle_all();
    @(negedge clk);
    chk("rn_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
